// File: rtl/scn_spi_sched.sv
// Static-screen SPI sequencer: power-up delay, init ROM streaming,
// then host/draw arbitration over the single SPI master.
module scn_spi_sched #(
    parameter int INIT_LEN     = 8,
    parameter int DELAY_CYCLES = 16
) (
    input  logic       sck,
    input  logic       rst_in,
    output logic [3:0] init_addr,
    input  logic [8:0] init_word,
    input  logic       host_req,
    input  logic       host_dc,
    input  logic [7:0] host_data,
    output logic       host_ack,
    input  logic       draw_req,
    input  logic [7:0] draw_data,
    input  logic       draw_last,
    output logic       draw_ack,
    output logic       spi_start,
    output logic       spi_dc,
    output logic [7:0] spi_data,
    input  logic       spi_done,
    output logic       ready,
    output logic [1:0] grant
);

    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [DW-1:0] DLY_LAST  = DW'(DELAY_CYCLES - 1);
    localparam logic [3:0]    INIT_LAST = 4'(INIT_LEN - 1);

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_HOST = 2'b01;
    localparam logic [1:0] G_DRAW = 2'b10;
    localparam logic [1:0] G_INIT = 2'b11;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_FETCH,
        START,
        ACCEPT,
        XFER,
        DONE,
        IDLE
    } state_t;

    state_t        state;
    logic [DW-1:0] dly_cnt;
    logic          lock;
    logic          cur_last;

    // Sequencer/arbiter FSM; every output is registered here.
    always_ff @(posedge sck) begin
        if (rst_in) begin
            state     <= PWR_WAIT;
            dly_cnt   <= '0;
            lock      <= 1'b0;
            cur_last  <= 1'b0;
            init_addr <= 4'd0;
            host_ack  <= 1'b0;
            draw_ack  <= 1'b0;
            spi_start <= 1'b0;
            spi_dc    <= 1'b0;
            spi_data  <= 8'd0;
            ready     <= 1'b0;
            grant     <= G_NONE;
        end else begin
            host_ack  <= 1'b0;
            draw_ack  <= 1'b0;
            spi_start <= 1'b0;
            unique case (state)
                PWR_WAIT: begin
                    if (dly_cnt == DLY_LAST) begin
                        state <= INIT_FETCH;
                        grant <= G_INIT;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                INIT_FETCH: begin
                    spi_dc   <= init_word[8];
                    spi_data <= init_word[7:0];
                    state    <= START;
                end
                START: begin
                    if (spi_done) begin
                        spi_start <= 1'b1;
                        state     <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (!spi_done) state <= XFER;
                end
                XFER: begin
                    if (spi_done) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    case (grant)
                        G_INIT: begin
                            if (init_addr == INIT_LAST) begin
                                ready     <= 1'b1;
                                init_addr <= 4'd0;
                            end else begin
                                init_addr <= init_addr + 4'd1;
                                state     <= INIT_FETCH;
                            end
                        end
                        G_HOST: host_ack <= 1'b1;
                        G_DRAW: begin
                            draw_ack <= 1'b1;
                            if (cur_last) lock <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                IDLE: begin
                    // The ack cycle still shows the served request, so
                    // arbitration waits one cycle after any ack.
                    grant <= G_NONE;
                    if (ready && !host_ack && !draw_ack) begin
                        if (host_req && !lock) begin
                            grant    <= G_HOST;
                            spi_dc   <= host_dc;
                            spi_data <= host_data;
                            state    <= START;
                        end else if (draw_req) begin
                            grant    <= G_DRAW;
                            spi_dc   <= 1'b1;
                            spi_data <= draw_data;
                            cur_last <= draw_last;
                            lock     <= 1'b1;
                            state    <= START;
                        end
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_scn_spi_sched.sv
// Bench for scn_spi_sched: SPI responder, requester agents and an
// ordered transfer scoreboard built from the arbitration rules.
module tb_scn_spi_sched;

    logic       sck = 1'b0;
    logic       rst_in = 1'b1;
    logic [3:0] init_addr;
    logic [8:0] init_word;
    logic       host_req = 1'b0;
    logic       host_dc = 1'b0;
    logic [7:0] host_data = 8'd0;
    logic       host_ack;
    logic       draw_req = 1'b0;
    logic [7:0] draw_data = 8'd0;
    logic       draw_last = 1'b0;
    logic       draw_ack;
    logic       spi_start;
    logic       spi_dc;
    logic [7:0] spi_data;
    logic       spi_done;
    logic       ready;
    logic [1:0] grant;

    int checks = 0;
    int errors = 0;

    always #5 sck = ~sck;

    scn_spi_sched #(.INIT_LEN(3), .DELAY_CYCLES(16)) dut (
        .sck(sck), .rst_in(rst_in),
        .init_addr(init_addr), .init_word(init_word),
        .host_req(host_req), .host_dc(host_dc),
        .host_data(host_data), .host_ack(host_ack),
        .draw_req(draw_req), .draw_data(draw_data),
        .draw_last(draw_last), .draw_ack(draw_ack),
        .spi_start(spi_start), .spi_dc(spi_dc),
        .spi_data(spi_data), .spi_done(spi_done),
        .ready(ready), .grant(grant)
    );

    logic [8:0] rom [0:15];
    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 9'h000;
        rom[0] = 9'h111;
        rom[1] = 9'h02A;
        rom[2] = 9'h1FF;
    end
    assign init_word = rom[init_addr];

    // SPI master model: busy for xfer_len cycles after a start.
    int          busy = 0;
    int          xfer_len = 8;
    bit          force_low = 1'b0;
    int          stab_err = 0;
    logic [8:0]  cur_byte = 9'd0;
    logic [10:0] sent_q [$];
    assign spi_done = (busy == 0) && !force_low;

    always @(posedge sck) begin
        if (rst_in) begin
            busy <= 0;
        end else if (busy == 0 && spi_start) begin
            busy     <= xfer_len;
            cur_byte <= {spi_dc, spi_data};
            sent_q.push_back({grant, spi_dc, spi_data});
        end else if (busy > 0) begin
            busy <= busy - 1;
            if ({spi_dc, spi_data} !== cur_byte) stab_err <= stab_err + 1;
        end
    end

    int host_acks = 0;
    int draw_acks = 0;
    bit ack_q [$];
    always @(posedge sck) begin
        if (host_ack) begin
            host_acks++;
            ack_q.push_back(1'b0);
        end
        if (draw_ack) begin
            draw_acks++;
            ack_q.push_back(1'b1);
        end
    end

    // Requester agents: hold req/data until ack, then present next item.
    logic [8:0] host_q [$];
    logic [8:0] draw_q [$];
    initial begin
        forever begin
            @(posedge sck);
            #1;
            if (host_req && host_ack) begin
                host_req = 1'b0;
                void'(host_q.pop_front());
            end
            if (!host_req && host_q.size() > 0) begin
                {host_dc, host_data} = host_q[0];
                host_req = 1'b1;
            end
        end
    end
    initial begin
        forever begin
            @(posedge sck);
            #1;
            if (draw_req && draw_ack) begin
                draw_req = 1'b0;
                void'(draw_q.pop_front());
            end
            if (!draw_req && draw_q.size() > 0) begin
                {draw_last, draw_data} = draw_q[0];
                draw_req = 1'b1;
            end
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs(string tag);
        check(tag, {init_addr, host_ack, draw_ack, spi_start,
                    spi_dc, spi_data, ready, grant}, 32'd0);
    endtask

    task automatic release_and_time(string tag);
        int cyc;
        cyc = 0;
        rst_in = 1'b0;
        while (!spi_start && cyc < 100) begin
            @(posedge sck);
            cyc++;
            @(negedge sck);
        end
        check(tag, cyc, 18);
    endtask

    task automatic wait_ready(string tag);
        int n;
        n = 0;
        while (!ready && n < 400) begin
            @(negedge sck);
            n++;
        end
        check(tag, ready, 1'b1);
    endtask

    task automatic wait_drain(string tag);
        int n;
        n = 0;
        while ((host_q.size() > 0 || draw_q.size() > 0 ||
                host_req || draw_req) && n < 2000) begin
            @(negedge sck);
            n++;
        end
        check({tag, "_drain"}, n < 2000, 1'b1);
        repeat (3) @(negedge sck);
    endtask

    task automatic cmp_sent(string tag, logic [10:0] exp [$]);
        check({tag, "_count"}, sent_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < sent_q.size()) check(tag, sent_q[i], exp[i]);
        end
        sent_q.delete();
    endtask

    task automatic cmp_acks(string tag, bit exp [$]);
        check({tag, "_count"}, ack_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < ack_q.size()) check(tag, ack_q[i], exp[i]);
        end
        ack_q.delete();
    endtask

    initial begin
        logic [10:0] exp_s [$];
        bit          exp_a [$];
        int          d0;
        int          n;
        int          mode;
        int          blen;
        logic [8:0]  hb;
        logic [7:0]  db;

        // Reset state
        repeat (3) @(posedge sck);
        @(negedge sck);
        check_reset_outs("reset_outs");

        // Power-up delay and init stream
        release_and_time("first_start_latency");
        wait_ready("init_ready");
        check("ready_after_third", sent_q.size(), 3);
        check("init_addr_cleared", init_addr, 4'd0);
        check("no_ack_in_init", host_acks + draw_acks, 0);
        exp_s.delete();
        for (int i = 0; i < 3; i++) exp_s.push_back({2'b11, rom[i]});
        cmp_sent("init_bytes", exp_s);
        repeat (2) @(negedge sck);
        check("grant_none_idle", grant, 2'b00);

        // Single host byte
        host_q.push_back({1'b0, 8'h2C});
        wait_drain("host1");
        exp_s.delete();
        exp_s.push_back({2'b01, 1'b0, 8'h2C});
        cmp_sent("host1", exp_s);
        check("host1_acks", host_acks, 1);
        exp_a.delete();
        exp_a.push_back(1'b0);
        cmp_acks("host1_order", exp_a);

        // Simultaneous host and draw: host wins
        host_q.push_back({1'b1, 8'h55});
        draw_q.push_back({1'b1, 8'h66});
        wait_drain("both");
        exp_s.delete();
        exp_s.push_back({2'b01, 1'b1, 8'h55});
        exp_s.push_back({2'b10, 1'b1, 8'h66});
        cmp_sent("both", exp_s);
        exp_a.delete();
        exp_a.push_back(1'b0);
        exp_a.push_back(1'b1);
        cmp_acks("both_order", exp_a);

        // Locked draw burst with host arriving mid-burst
        for (int i = 0; i < 4; i++)
            draw_q.push_back({(i == 3), 8'hA0 + 8'(i)});
        d0 = draw_acks;
        n = 0;
        while (draw_acks == d0 && n < 200) begin
            @(negedge sck);
            n++;
        end
        check("burst_first_ack", draw_acks, d0 + 1);
        host_q.push_back({1'b0, 8'h77});
        wait_drain("burst");
        exp_s.delete();
        exp_a.delete();
        for (int i = 0; i < 4; i++) begin
            exp_s.push_back({2'b10, 1'b1, 8'hA0 + 8'(i)});
            exp_a.push_back(1'b1);
        end
        exp_s.push_back({2'b01, 1'b0, 8'h77});
        exp_a.push_back(1'b0);
        cmp_sent("burst", exp_s);
        cmp_acks("burst_order", exp_a);

        // spi_done held low at a start attempt
        force_low = 1'b1;
        host_q.push_back({1'b1, 8'h3C});
        for (int i = 0; i < 20; i++) begin
            @(negedge sck);
            check("hold_no_start", spi_start, 1'b0);
        end
        check("hold_grant", grant, 2'b01);
        force_low = 1'b0;
        @(negedge sck);
        check("hold_release_start", spi_start, 1'b1);
        wait_drain("hold");
        exp_s.delete();
        exp_s.push_back({2'b01, 1'b1, 8'h3C});
        cmp_sent("hold", exp_s);
        ack_q.delete();

        // Randomized traffic against the ordering rules
        for (int it = 0; it < 12; it++) begin
            xfer_len = $urandom_range(1, 8);
            mode = $urandom_range(0, 2);
            blen = $urandom_range(1, 3);
            hb = 9'($urandom);
            exp_s.delete();
            exp_a.delete();
            if (mode != 1) begin
                host_q.push_back(hb);
                exp_s.push_back({2'b01, hb});
                exp_a.push_back(1'b0);
            end
            if (mode != 0) begin
                for (int i = 0; i < blen; i++) begin
                    db = 8'($urandom);
                    draw_q.push_back({(i == blen - 1), db});
                    exp_s.push_back({2'b10, 1'b1, db});
                    exp_a.push_back(1'b1);
                end
            end
            wait_drain("rand");
            cmp_sent("rand", exp_s);
            cmp_acks("rand_order", exp_a);
        end
        check("data_stable", stab_err, 0);

        // Reset during a draw transfer
        xfer_len = 8;
        draw_q.push_back({1'b1, 8'h99});
        n = 0;
        while (!(grant == 2'b10 && !spi_done) && n < 200) begin
            @(negedge sck);
            n++;
        end
        check("rst_reach_xfer", n < 200, 1'b1);
        repeat (2) @(negedge sck);
        d0 = draw_acks;
        rst_in = 1'b1;
        @(negedge sck);
        check_reset_outs("rst_mid_outs");
        sent_q.delete();
        ack_q.delete();
        release_and_time("replay_latency");
        check("replay_no_ack", draw_acks, d0);
        wait_ready("replay_ready");
        check("replay_ack_in_init", draw_acks, d0);
        wait_drain("replay");
        exp_s.delete();
        for (int i = 0; i < 3; i++) exp_s.push_back({2'b11, rom[i]});
        exp_s.push_back({2'b10, 1'b1, 8'h99});
        cmp_sent("replay", exp_s);
        check("replay_draw_ack", draw_acks, d0 + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
